magic_side_data_get: RTL and testbench

Reader counterpart of the per-side facelet writer. It snapshots one 27-bit side word on `enable`, then streams its nine 3-bit colour fields out in position order 1..9 over a valid/ready handshake, and pulses `done` at the end. It sits between the side-state registers and downstream consumers such as the UART dumper or the display renderer.

---
 rtl/magic_cube_pkg.sv | 17 +
 rtl/magic_side_field_mux.sv | 20 ++
 rtl/magic_side_data_get.sv | 147 ++++++++++++++
 tb/tb_magic_side_data_get.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/magic_cube_pkg.sv
// Shared constants and types for the side-state reader/writer blocks.
package magic_cube_pkg;

   localparam int unsigned COLOR_W   = 3;
   localparam int unsigned FACELET_N = 9;
   localparam int unsigned SIDE_W    = 27;
   localparam int unsigned POS_W     = 9;
   localparam int unsigned IDX_W     = 4;
   localparam int unsigned CENTER_K  = 5;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StSend = 2'd1,
      StDone = 2'd2
   } side_get_state_t;

endpackage

// File: rtl/magic_side_field_mux.sv
// Selects colour field k (1..9) from a 27-bit side word; index 0 or >9 yields 0.
module magic_side_field_mux
   import magic_cube_pkg::*;
(
   input  logic [SIDE_W-1:0]  word_i,
   input  logic [IDX_W-1:0]   idx_i,
   output logic [COLOR_W-1:0] field_o
);

   // Compare against each legal index; out-of-range falls through to zero.
   always_comb begin
      field_o = '0;
      for (int k = 1; k <= FACELET_N; k++) begin
         if (idx_i == IDX_W'(k)) begin
            field_o = word_i[k*COLOR_W-1 -: COLOR_W];
         end
      end
   end

endmodule

// File: rtl/magic_side_data_get.sv
// Snapshots one side word on enable and streams its nine colour fields over
// valid/ready, then pulses done. Optional centre-colour check is enabled by
// defining MAGIC_SIDE_CENTER_CHECK_EN.
module magic_side_data_get
   import magic_cube_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic [SIDE_W-1:0]  oneside_din,
   input  logic               out_ready,
`ifdef MAGIC_SIDE_CENTER_CHECK_EN
   input  logic [COLOR_W-1:0] expect_center,
   output logic               center_err,
`endif
   output logic [POS_W-1:0]   pos_out,
   output logic [COLOR_W-1:0] color_out,
   output logic               out_valid,
   output logic               busy,
   output logic               done
);

   side_get_state_t    state_q, state_d;
   logic [SIDE_W-1:0]  snap_q, snap_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [POS_W-1:0]   pos_q, pos_d;
   logic [COLOR_W-1:0] color_q, color_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
`ifdef MAGIC_SIDE_CENTER_CHECK_EN
   logic [COLOR_W-1:0] exp_q, exp_d;
   logic               cerr_q, cerr_d;
`endif

   logic [SIDE_W-1:0]  mux_word;
   logic [IDX_W-1:0]   mux_idx;
   logic [COLOR_W-1:0] mux_field;

   magic_side_field_mux u_field_mux (
      .word_i  (mux_word),
      .idx_i   (mux_idx),
      .field_o (mux_field)
   );

   // Next-state and registered-output computation; the mux looks one field ahead.
   always_comb begin
      state_d  = state_q;
      snap_d   = snap_q;
      idx_d    = idx_q;
      pos_d    = pos_q;
      color_d  = color_q;
      valid_d  = valid_q;
      done_d   = 1'b0;
`ifdef MAGIC_SIDE_CENTER_CHECK_EN
      exp_d    = exp_q;
      cerr_d   = 1'b0;
`endif
      // In IDLE the first field comes straight from the input word being captured.
      mux_word = snap_q;
      mux_idx  = idx_q + 4'd1;

      case (state_q)
         StIdle: begin
            mux_word = oneside_din;
            mux_idx  = 4'd1;
            if (enable) begin
               snap_d  = oneside_din;
               idx_d   = 4'd1;
               pos_d   = POS_W'(1);
               color_d = mux_field;
               valid_d = 1'b1;
               state_d = StSend;
`ifdef MAGIC_SIDE_CENTER_CHECK_EN
               exp_d   = expect_center;
`endif
            end
         end
         StSend: begin
            if (valid_q && out_ready) begin
               if (idx_q == IDX_W'(FACELET_N)) begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = StDone;
`ifdef MAGIC_SIDE_CENTER_CHECK_EN
                  cerr_d  = (snap_q[CENTER_K*COLOR_W-1 -: COLOR_W] != exp_q);
`endif
               end else begin
                  idx_d   = idx_q + 4'd1;
                  pos_d   = POS_W'(idx_q + 4'd1);
                  color_d = mux_field;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
            valid_d = 1'b0;
         end
      endcase

      busy_d = (state_d != StIdle);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         snap_q  <= '0;
         idx_q   <= '0;
         pos_q   <= '0;
         color_q <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef MAGIC_SIDE_CENTER_CHECK_EN
         exp_q   <= '0;
         cerr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         idx_q   <= idx_d;
         pos_q   <= pos_d;
         color_q <= color_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef MAGIC_SIDE_CENTER_CHECK_EN
         exp_q   <= exp_d;
         cerr_q  <= cerr_d;
`endif
      end
   end

   assign pos_out   = pos_q;
   assign color_out = color_q;
   assign out_valid = valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
`ifdef MAGIC_SIDE_CENTER_CHECK_EN
   assign center_err = cerr_q;
`endif

endmodule

// File: tb/tb_magic_side_data_get.sv
// Self-checking bench for magic_side_data_get: table of directed streams, a
// reset-abort sequence and randomized streams against a beat-queue model.
module tb_magic_side_data_get;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic [26:0] oneside_din;
   logic        out_ready;
   logic [2:0]  expect_center;
   logic [8:0]  pos_out;
   logic [2:0]  color_out;
   logic        out_valid;
   logic        busy;
   logic        done;
`ifdef MAGIC_SIDE_CENTER_CHECK_EN
   logic        center_err;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   magic_side_data_get dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .oneside_din (oneside_din),
      .out_ready   (out_ready),
`ifdef MAGIC_SIDE_CENTER_CHECK_EN
      .expect_center (expect_center),
      .center_err    (center_err),
`endif
      .pos_out     (pos_out),
      .color_out   (color_out),
      .out_valid   (out_valid),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [26:0] word;
      int          mode;      // 0: ready high, 1: ready on odd cycles, 2: random
      logic [2:0]  exp_c;
      bit          poke;      // scramble din/enable while streaming
      int          exp_done;  // expected done cycle after enable, <0 to skip
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] field_of(input logic [26:0] w, input int k);
      logic [26:0] s;
      s = w >> (3 * (k - 1));
      return s[2:0];
   endfunction

   // Model: the snapshot yields beats (k, field k) for k=1..9 in order; each
   // accepted beat pops, done follows the cycle after the last pop.
   task automatic run_stream(input logic [26:0] word, input int mode, input logic [2:0] exp_c,
                             input bit poke, input int exp_done);
      int  next_k;
      int  done_at;
      bit  finished;
      oneside_din   = word;
      expect_center = exp_c;
      enable        = 1'b1;
      out_ready     = 1'b0;
      step();
      enable   = 1'b0;
      next_k   = 1;
      done_at  = -1;
      finished = 1'b0;
      for (int c = 1; c < 200; c++) begin
         if (next_k <= 9) begin
            chk("beat_valid", out_valid, 1);
            chk("beat_busy", busy, 1);
            chk("beat_done", done, 0);
            chk("beat_pos", pos_out, next_k);
            chk("beat_color", color_out, field_of(word, next_k));
         end else if (done_at < 0) begin
            done_at = c;
            chk("done_pulse", done, 1);
            chk("valid_at_done", out_valid, 0);
            chk("busy_at_done", busy, 1);
`ifdef MAGIC_SIDE_CENTER_CHECK_EN
            chk("center_err", center_err, field_of(word, 5) != exp_c);
`endif
         end else begin
            chk("done_after", done, 0);
            chk("busy_idle", busy, 0);
            chk("valid_idle", out_valid, 0);
            finished = 1'b1;
            break;
         end
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (c % 2 == 1);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
         if (poke) begin
            oneside_din = 27'($urandom);
            enable      = 1'($urandom_range(0, 1));
         end
         if (next_k <= 9 && out_ready) next_k++;
         step();
      end
      enable = 1'b0;
      if (!finished) chk("stream_timeout", 0, 1);
      if (exp_done > 0) chk("done_cycle", done_at, exp_done);
   endtask

   initial begin
      vec_t        tbl [6];
      logic [26:0] base;
      logic [26:0] cw;

      base = '0;
      for (int k = 1; k <= 9; k++) base[3*k-1 -: 3] = 3'((k - 1) % 8);
      cw = base;
      cw[14:12] = 3'd2;

      tbl[0] = '{base, 0, 3'd0, 1'b0, 10};
      tbl[1] = '{base, 1, 3'd0, 1'b0, 18};
      tbl[2] = '{base, 0, 3'd0, 1'b1, 10};
      tbl[3] = '{27'h5a5a5a5, 1, 3'd0, 1'b1, 18};
      tbl[4] = '{cw, 0, 3'd2, 1'b0, 10};
      tbl[5] = '{cw, 0, 3'd4, 1'b0, 10};

      rst = 1'b1; enable = 1'b0; out_ready = 1'b0; oneside_din = '0; expect_center = '0;
      step();
      step();
      chk("rst_pos", pos_out, 0);
      chk("rst_color", color_out, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
`ifdef MAGIC_SIDE_CENTER_CHECK_EN
      chk("rst_center_err", center_err, 0);
`endif
      rst = 1'b0;
      step();

      for (int i = 0; i < 6; i++) begin
         run_stream(tbl[i].word, tbl[i].mode, tbl[i].exp_c, tbl[i].poke, tbl[i].exp_done);
         step();
         chk("gap_valid", out_valid, 0);
      end

      // Reset during beat 4 aborts with no done, then a fresh start begins at 1.
      oneside_din = base; enable = 1'b1; out_ready = 1'b1;
      step();
      enable = 1'b0;
      for (int c = 1; c < 4; c++) step();
      chk("pre_rst_pos", pos_out, 4);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_pos", pos_out, 0);
      chk("abort_color", color_out, 0);
      chk("abort_valid", out_valid, 0);
      chk("abort_done", done, 0);
      chk("abort_busy", busy, 0);
      for (int c = 0; c < 3; c++) begin
         step();
         chk("abort_no_done", done, 0);
         chk("abort_idle_valid", out_valid, 0);
      end
      run_stream(base, 0, 3'd0, 1'b0, 10);
      step();

      for (int i = 0; i < 20; i++) begin
         run_stream(27'($urandom), 2, 3'($urandom), (i % 2) == 1, -1);
         step();
         chk("rand_gap_valid", out_valid, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
